// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_if
//  Brief    : Request/response bundle between execute stage and muldiv_unit.
//  Revision : 1.0
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [XLEN-1:0] Result;
    logic            busy;
    logic            done;

    modport master (
        output start, funct3, A, B,
        input  Result, busy, done
    );

    modport slave (
        input  start, funct3, A, B,
        output Result, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Brief    : Iterative RV32M multiply/divide (shift-add / restoring divide).
//  Revision : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    muldiv_if.slave   bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [4:0]      r_count;
    logic [2:0]      r_funct3;
    logic            r_neg_a;
    logic            r_neg_b;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_result;

    // Operand decode on the incoming request
    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic [XLEN-1:0] w_fast_result;

    assign w_accept   = bus.start && (r_state == c_IDLE || r_state == c_DONE);
    assign w_a_signed = !(bus.funct3 == 3'b011 || bus.funct3 == 3'b101 || bus.funct3 == 3'b111);
    assign w_b_signed = w_a_signed && (bus.funct3 != 3'b010);
    assign w_neg_a    = w_a_signed && bus.A[XLEN-1];
    assign w_neg_b    = w_b_signed && bus.B[XLEN-1];
    assign w_abs_a    = w_neg_a ? (~bus.A + 1'b1) : bus.A;
    assign w_abs_b    = w_neg_b ? (~bus.B + 1'b1) : bus.B;
    assign w_div_zero = bus.funct3[2] && (bus.B == '0);
    assign w_div_ovf  = bus.funct3[2] && !bus.funct3[0]
                        && (bus.A == {1'b1, {(XLEN-1){1'b0}}})
                        && (bus.B == {XLEN{1'b1}});

    always_comb begin
        w_fast_result = '0;
        if (w_div_zero) begin
            w_fast_result = bus.funct3[1] ? bus.A : {XLEN{1'b1}};
        end else begin
            w_fast_result = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    // Multiply step: 33-bit add keeps the carry, which shifts into the top bit
    logic [XLEN:0]   w_add;
    logic [XLEN:0]   w_mul_hi;
    assign w_add    = {1'b0, r_hi} + {1'b0, r_opb};
    assign w_mul_hi = r_lo[0] ? w_add : {1'b0, r_hi};

    // Divide step: shifted remainder can reach 33 bits before the compare
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_opb});
    assign w_diff   = w_rem_sh[XLEN-1:0] - r_opb;

    // Sign fix-up and result selection
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_result;
    assign w_prod = (r_neg_a ^ r_neg_b) ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
    assign w_quot = (r_neg_a ^ r_neg_b) ? (~r_lo + 1'b1) : r_lo;
    assign w_rem  = r_neg_a ? (~r_hi + 1'b1) : r_hi;

    always_comb begin
        w_fix_result = '0;
        case (r_funct3)
            3'b000:                 w_fix_result = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_result = w_quot;
            default:                w_fix_result = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_count  <= '0;
            r_funct3 <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_funct3 <= bus.funct3;
                        r_neg_a  <= w_neg_a;
                        r_neg_b  <= w_neg_b;
                        r_count  <= '0;
                        r_hi     <= '0;
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_fast_result;
                            r_state  <= c_DONE;
                        end else begin
                            // Divide keeps dividend in lo; multiply keeps multiplier in lo
                            r_lo    <= bus.funct3[2] ? w_abs_a : w_abs_b;
                            r_opb   <= bus.funct3[2] ? w_abs_b : w_abs_a;
                            r_state <= c_CALC;
                        end
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_CALC: begin
                    if (r_funct3[2]) begin
                        r_hi <= w_ge ? w_diff : w_rem_sh[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_hi <= w_mul_hi[XLEN:1];
                        r_lo <= {w_mul_hi[0], r_lo[XLEN-1:1]};
                    end
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    r_result <= w_fix_result;
                    r_state  <= c_DONE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign bus.Result = r_result;
    assign bus.busy   = (r_state == c_CALC) || (r_state == c_FIX);
    assign bus.done   = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Brief    : Directed self-checking bench for muldiv_unit.
//  Revision : 1.0
// ============================================================================
module tb_muldiv_unit;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives the request for one edge, then waits for done.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_n;
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.A      = a;
        bus.B      = b;
        @(posedge clk);
        lat    = 1;
        busy_n = 0;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_n++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_result"}, {32'd0, bus.Result}, {32'd0, exp});
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busycycles"}, busy_n, (exp_lat == 1) ? 0 : exp_lat - 1);
        check({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    endtask

    // One idle cycle after a done: done must drop and Result must hold.
    task automatic idle_check(input string tag, input logic [31:0] exp);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_drop"}, {63'd0, bus.done}, 64'd0);
        check({tag, "_hold"}, {32'd0, bus.Result}, {32'd0, exp});
    endtask

    initial begin
        int lat;
        int seen_done;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_result", {32'd0, bus.Result}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);

        do_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        idle_check("mul_7_m3", 32'hFFFFFFEB);
        do_op("mulh_min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        do_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        do_op("mulhsu_m1", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        do_op("div_m7_2", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        do_op("rem_m7_2", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 34);
        idle_check("remu_100_7", 32'd2);
        do_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
        idle_check("divu_5_0", 32'hFFFFFFFF);
        do_op("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
        do_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);
        idle_check("rem_ovf", 32'd0);

        // A second start during CALC must be ignored
        bus.start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.A      = 32'd1000;
        bus.B      = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.A      = 32'd5;
        bus.B      = 32'd6;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("ignore_start_result", {32'd0, bus.Result}, 64'd111);
        check("ignore_start_timely", {63'd0, bus.done}, 64'd1);

        // Reset ten cycles into an op discards it
        @(posedge clk);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.A      = 32'd100;
        bus.B      = 32'd100;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_result", {32'd0, bus.Result}, 64'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen_done = 1;
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_no_done", seen_done, 0);

        do_op("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, 34);
        // Called in the DONE cycle: accepted back-to-back
        do_op("b2b_divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 34);
        idle_check("b2b_divu_9_3", 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage. The ALU covers the base RV32I arithmetic. This block covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU: it accepts operands with a start pulse, computes over multiple cycles with radix-2 shift-add or restoring division, and returns a result with a one-cycle done pulse. The pipeline stalls on `busy`.

## Interface
- XLEN, 32, operand/result width; only 32 is supported
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- funct3  input  3  op select, instruction[14:12]: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  input  32  rs1 operand (multiplicand/dividend)
- B  input  32  rs2 operand (multiplier/divisor)
- Result  output  32  result; valid when done=1, held until next accepted start
- busy  output  1  operation in progress; start ignored while high
- done  output  1  one-cycle pulse, Result valid

## Operation
- States: IDLE, CALC, FIX, DONE. Reset: state=IDLE, Result=0, busy=0, done=0, counter=0, internal regs=0.
- IDLE/DONE + start=1: latch funct3, compute sign flags, latch |A|,|B| per op:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
  - Go to CALC with counter=0.
- IDLE/DONE + start=0: go to / stay in IDLE.
- Fast path, from IDLE/DONE + start:
  - Divide-by-zero (B=0, funct3[2]=1): go directly to DONE. DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): go directly to DONE. DIV gives 0x80000000; REM gives 0.
- CALC, multiply: 64-bit product register. Each cycle, if multiplier LSB=1 add multiplicand into upper half, then shift right 1 with carry-in. The add is 33-bit; the carry must not be lost.
- CALC, divide: restoring division. Shift {rem,quot} left 1; if rem ≥ divisor, subtract and set quot LSB.
- CALC runs exactly 32 cycles (counter 0..31), then goes to FIX.
- FIX: negate magnitude if the sign is negative.
  - Product sign: A_neg XOR B_neg (B_neg=0 for MULHSU/MULHU).
  - Quotient sign: A_neg XOR B_neg.
  - Remainder sign: A_neg.
  - Select low product (MUL), high product (MULH*), quotient or remainder. Write Result, go to DONE.
- DONE: done=1, busy=0 for one cycle. start accepted here behaves as from IDLE (back-to-back).
- rst at any state: immediate return to IDLE. In-flight op discarded, no done pulse, Result=0.
- Operand or funct3 changes after acceptance have no effect.

## Timing
- Start accepted at edge T0. busy=1 from T0 through the edge that enters DONE.
- Normal op: CALC during cycles T0..T31, FIX at T32, done=1 and Result valid in cycle after edge T33. Latency is 34 cycles from start edge to done.
- Fast path: done=1 in cycle after T0 (latency 1); busy stays 0.
- done is never high for two consecutive cycles unless a new fast-path op is accepted in the DONE cycle.
- busy and done are never both 1.
- Result changes only on the FIX→DONE edge, the fast-path edge, or reset.

## Test plan
- MUL, A=7, B=0xFFFFFFFD (-3) -> Result=0xFFFFFFEB, done exactly 34 cycles after start, busy high 33 cycles.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100,7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5,0 -> 5, each with done one cycle after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- start re-asserted with different operands during CALC is ignored; the original result is returned. rst asserted at cycle 10 of an op gives busy=0, Result=0, no done. The next MUL 3×4 -> 12.
- start asserted in the DONE cycle (DIVU 9/3) is accepted back-to-back: done 34 cycles later with Result=3.
